core_sequencer: RTL and testbench

Multi-cycle control FSM for the core: issues one-cycle `enable` pulses to fetch, decode, exec, mem and write stages in order and advances on each stage's `done` pulse. Skips the mem stage when decode reports no memory access, counts retired instructions, stops cleanly on halt, and traps a hung stage with a watchdog. It sits at the top of the core, with every stage's enable/done pair wired to it.

---
 rtl/core_pkg.sv | 59 +++++
 rtl/core_sequencer_if.sv | 27 ++
 rtl/seq_watchdog.sv | 34 +++
 rtl/core_sequencer.sv | 162 ++++++++++++++++
 tb/tb_core_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Sequencer state encoding and 3-bit stage codes shared by the sequencer,
// the stage modules and debug logic.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WRITE  = 3'd5,
    ST_HALTED = 3'd6,
    ST_FAULT  = 3'd7
  } seq_state_e;

  localparam logic [2:0] STAGE_NONE   = 3'd0;
  localparam logic [2:0] STAGE_FETCH  = 3'd1;
  localparam logic [2:0] STAGE_DECODE = 3'd2;
  localparam logic [2:0] STAGE_EXEC   = 3'd3;
  localparam logic [2:0] STAGE_MEM    = 3'd4;
  localparam logic [2:0] STAGE_WRITE  = 3'd5;

  function automatic logic is_stage(input seq_state_e s);
    logic r;
    case (s)
      ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WRITE: r = 1'b1;
      default:                                        r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] stage_code(input seq_state_e s);
    logic [2:0] r;
    case (s)
      ST_FETCH:  r = STAGE_FETCH;
      ST_DECODE: r = STAGE_DECODE;
      ST_EXEC:   r = STAGE_EXEC;
      ST_MEM:    r = STAGE_MEM;
      ST_WRITE:  r = STAGE_WRITE;
      default:   r = STAGE_NONE;
    endcase
    return r;
  endfunction

  // Enable vector bit order: {write, mem, exec, decode, fetch}.
  function automatic logic [4:0] stage_onehot(input seq_state_e s);
    logic [4:0] r;
    case (s)
      ST_FETCH:  r = 5'b00001;
      ST_DECODE: r = 5'b00010;
      ST_EXEC:   r = 5'b00100;
      ST_MEM:    r = 5'b01000;
      ST_WRITE:  r = 5'b10000;
      default:   r = 5'b00000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Enable/done handshakes between the core sequencer and its pipeline stages.
interface core_sequencer_if;

  logic fetch_enable;
  logic fetch_done;
  logic decode_enable;
  logic decode_done;
  logic decode_mem;
  logic decode_halt;
  logic exec_enable;
  logic exec_done;
  logic mem_enable;
  logic mem_done;
  logic write_enable;
  logic write_done;

  modport master (
    output fetch_enable, decode_enable, exec_enable, mem_enable, write_enable,
    input  fetch_done, decode_done, decode_mem, decode_halt, exec_done, mem_done, write_done
  );

  modport slave (
    input  fetch_enable, decode_enable, exec_enable, mem_enable, write_enable,
    output fetch_done, decode_done, decode_mem, decode_halt, exec_done, mem_done, write_done
  );

endinterface

// File: rtl/seq_watchdog.sv
// Stage watchdog: counts waiting cycles since the last enable pulse and flags
// the cycle in which the count would reach TIMEOUT_CYCLES-1.
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] cnt_r;

  // Expiry is combinational so the FSM can trap in the same cycle a done could still win.
  assign expired = run && (cnt_r == LAST_CNT);

  // Wait-cycle counter; holds at the last count rather than wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (run && !expired) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Core sequencer: walks fetch/decode/exec/[mem]/write with one-cycle enable
// pulses, counts retired instructions, halts cleanly and traps hung stages.
module core_sequencer
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             halt_req,
  core_sequencer_if.master stg,
  output logic             running,
  output logic             fault,
  output logic [2:0]       fault_stage,
  output logic [31:0]      retired
);

  seq_state_e state_r;
  seq_state_e state_next_s;
  seq_state_e hold_s;

  logic [4:0] en_r;
  logic [4:0] en_next_s;
  logic       running_next_s;
  logic       fault_next_s;
  logic [2:0] fault_stage_next_s;

  logic stage_done_s;
  logic done_s;
  logic entering_s;
  logic expired_s;
  logic wd_run_s;
  logic halt_now_s;

  logic mem_flag_r;
  logic halt_flag_r;
  logic halt_pend_r;

  assign stg.fetch_enable  = en_r[0];
  assign stg.decode_enable = en_r[1];
  assign stg.exec_enable   = en_r[2];
  assign stg.mem_enable    = en_r[3];
  assign stg.write_enable  = en_r[4];

  assign wd_run_s   = is_stage(state_r);
  assign halt_now_s = halt_flag_r | halt_pend_r | halt_req;
  assign hold_s     = expired_s ? ST_FAULT : state_r;

  // A done coinciding with the enable pulse (entry cycle) is not accepted.
  assign done_s = stage_done_s & ~(|en_r);

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (entering_s),
    .run    (wd_run_s),
    .expired(expired_s)
  );

  // Select the done input of the currently active stage.
  always_comb begin
    stage_done_s = 1'b0;
    case (state_r)
      ST_FETCH:  stage_done_s = stg.fetch_done;
      ST_DECODE: stage_done_s = stg.decode_done;
      ST_EXEC:   stage_done_s = stg.exec_done;
      ST_MEM:    stage_done_s = stg.mem_done;
      ST_WRITE:  stage_done_s = stg.write_done;
      default:   stage_done_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_FETCH:  state_next_s = done_s ? ST_DECODE : hold_s;
      ST_DECODE: state_next_s = done_s ? ST_EXEC : hold_s;
      ST_EXEC:   state_next_s = done_s ? (mem_flag_r ? ST_MEM : ST_WRITE) : hold_s;
      ST_MEM:    state_next_s = done_s ? ST_WRITE : hold_s;
      ST_WRITE:  state_next_s = done_s ? (halt_now_s ? ST_HALTED : ST_FETCH) : hold_s;
      ST_FAULT:  state_next_s = ST_FAULT;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs.
  always_comb begin
    entering_s = (state_next_s != state_r) && is_stage(state_next_s);
    if (entering_s) begin
      en_next_s = stage_onehot(state_next_s);
    end else begin
      en_next_s = 5'b00000;
    end
    running_next_s = is_stage(state_next_s);
    if ((state_next_s == ST_FAULT) && (state_r != ST_FAULT)) begin
      fault_next_s       = 1'b1;
      fault_stage_next_s = stage_code(state_r);
    end else begin
      fault_next_s       = fault;
      fault_stage_next_s = fault_stage;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_r        <= 5'b00000;
      running     <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= STAGE_NONE;
    end else begin
      en_r        <= en_next_s;
      running     <= running_next_s;
      fault       <= fault_next_s;
      fault_stage <= fault_stage_next_s;
    end
  end

  // Decode flags, pending halt request and retired-instruction counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_flag_r  <= 1'b0;
      halt_flag_r <= 1'b0;
      halt_pend_r <= 1'b0;
      retired     <= 32'd0;
    end else begin
      if ((state_r == ST_DECODE) && done_s) begin
        mem_flag_r  <= stg.decode_mem;
        halt_flag_r <= stg.decode_halt;
      end
      if (state_next_s == ST_HALTED) begin
        halt_pend_r <= 1'b0;
      end else if (is_stage(state_r) && halt_req) begin
        halt_pend_r <= 1'b1;
      end
      if ((state_r == ST_WRITE) && done_s) begin
        retired <= retired + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed table-driven bench for core_sequencer plus hand-written sequences
// for watchdog trap, async reset mid-instruction and retired wrap-around.
module tb_core_sequencer;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        running;
  logic        fault;
  logic [2:0]  fault_stage;
  logic [31:0] retired;

  core_sequencer_if stg();

  core_sequencer #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .halt_req   (halt_req),
    .stg        (stg),
    .running    (running),
    .fault      (fault),
    .fault_stage(fault_stage),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  // Input bits {start, halt_req, fetch_done, decode_done, decode_mem, decode_halt, exec_done, mem_done, write_done}
  localparam logic [8:0] I_0  = 9'h000;
  localparam logic [8:0] I_S  = 9'h100;
  localparam logic [8:0] I_H  = 9'h080;
  localparam logic [8:0] I_FD = 9'h040;
  localparam logic [8:0] I_DD = 9'h020;
  localparam logic [8:0] I_DM = 9'h010;
  localparam logic [8:0] I_DH = 9'h008;
  localparam logic [8:0] I_ED = 9'h004;
  localparam logic [8:0] I_MD = 9'h002;
  localparam logic [8:0] I_WD = 9'h001;

  // Enable bits {write, mem, exec, decode, fetch}
  localparam logic [4:0] E_0 = 5'h00;
  localparam logic [4:0] E_F = 5'h01;
  localparam logic [4:0] E_D = 5'h02;
  localparam logic [4:0] E_X = 5'h04;
  localparam logic [4:0] E_M = 5'h08;
  localparam logic [4:0] E_W = 5'h10;

  typedef struct packed {
    logic [8:0]  in;
    logic [4:0]  en;
    logic        run;
    logic [31:0] ret;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [8:0] in, input logic [4:0] en,
                              input logic run, input logic [31:0] ret);
    vec_t v;
    v.in  = in;
    v.en  = en;
    v.run = run;
    v.ret = ret;
    return v;
  endfunction

  function automatic logic [4:0] en_now();
    return {stg.write_enable, stg.mem_enable, stg.exec_enable, stg.decode_enable, stg.fetch_enable};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [8:0] in);
    start           = in[8];
    halt_req        = in[7];
    stg.fetch_done  = in[6];
    stg.decode_done = in[5];
    stg.decode_mem  = in[4];
    stg.decode_halt = in[3];
    stg.exec_done   = in[2];
    stg.mem_done    = in[1];
    stg.write_done  = in[0];
  endtask

  // Inputs applied at the falling edge, outputs observed at the next falling edge.
  task automatic step(input logic [8:0] in);
    drive(in);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".en"}, 32'(en_now()), 32'd0);
    chk({tag, ".running"}, 32'(running), 32'd0);
    chk({tag, ".fault"}, 32'(fault), 32'd0);
    chk({tag, ".fault_stage"}, 32'(fault_stage), 32'd0);
    chk({tag, ".retired"}, retired, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    drive(I_0);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Cycle k inputs -> expected outputs in cycle k+1.
    vq.push_back(mk(I_S,         E_F, 1'b1, 32'd0));  // 0
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd0));
    vq.push_back(mk(I_FD,        E_D, 1'b1, 32'd0));
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd0));
    vq.push_back(mk(I_DD,        E_X, 1'b1, 32'd0));
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd0));
    vq.push_back(mk(I_ED,        E_W, 1'b1, 32'd0));
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd0));
    vq.push_back(mk(I_WD,        E_F, 1'b1, 32'd1));  // 8
    vq.push_back(mk(I_FD,        E_0, 1'b1, 32'd1));  // done with enable: ignored
    vq.push_back(mk(I_FD,        E_D, 1'b1, 32'd1));
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd1));
    vq.push_back(mk(I_MD | I_S,  E_0, 1'b1, 32'd1));  // spurious mem_done, start ignored
    vq.push_back(mk(I_DD | I_DM, E_X, 1'b1, 32'd1));
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd1));
    vq.push_back(mk(I_ED,        E_M, 1'b1, 32'd1));
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd1));
    vq.push_back(mk(I_MD,        E_W, 1'b1, 32'd1));
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd1));
    vq.push_back(mk(I_WD,        E_F, 1'b1, 32'd2));  // 19
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd2));
    vq.push_back(mk(I_FD,        E_D, 1'b1, 32'd2));
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd2));
    vq.push_back(mk(I_DD,        E_X, 1'b1, 32'd2));
    vq.push_back(mk(I_H,         E_0, 1'b1, 32'd2));  // halt request during exec
    vq.push_back(mk(I_ED,        E_W, 1'b1, 32'd2));
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd2));
    vq.push_back(mk(I_WD,        E_0, 1'b0, 32'd3));  // 27: halted
    vq.push_back(mk(I_FD,        E_0, 1'b0, 32'd3));
    vq.push_back(mk(I_S,         E_F, 1'b1, 32'd3));  // resume, retired kept
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd3));
    vq.push_back(mk(I_FD,        E_D, 1'b1, 32'd3));
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd3));
    vq.push_back(mk(I_DD | I_DH, E_X, 1'b1, 32'd3));  // halt instruction
    vq.push_back(mk(I_ED,        E_0, 1'b1, 32'd3));
    vq.push_back(mk(I_ED,        E_W, 1'b1, 32'd3));
    vq.push_back(mk(I_WD,        E_0, 1'b1, 32'd3));
    vq.push_back(mk(I_WD,        E_0, 1'b0, 32'd4));  // 37: halted
    vq.push_back(mk(I_S | I_H,   E_F, 1'b1, 32'd4));  // halt_req ignored while halted
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd4));
    vq.push_back(mk(I_FD,        E_D, 1'b1, 32'd4));
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd4));
    vq.push_back(mk(I_DD,        E_X, 1'b1, 32'd4));
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd4));
    vq.push_back(mk(I_ED,        E_W, 1'b1, 32'd4));
    vq.push_back(mk(I_0,         E_0, 1'b1, 32'd4));
    vq.push_back(mk(I_WD,        E_F, 1'b1, 32'd5));  // 46

    foreach (vq[i]) begin
      step(vq[i].in);
      chk($sformatf("vec%0d.en", i), 32'(en_now()), 32'(vq[i].en));
      chk($sformatf("vec%0d.running", i), 32'(running), 32'(vq[i].run));
      chk($sformatf("vec%0d.retired", i), retired, vq[i].ret);
      chk($sformatf("vec%0d.fault", i), 32'(fault), 32'd0);
    end

    // Watchdog: exec_done never arrives, TIMEOUT_CYCLES = 8.
    step(I_0);
    step(I_FD);
    step(I_0);
    step(I_DD);
    chk("wd.exec_enable", 32'(en_now()), 32'(E_X));
    for (int k = 1; k <= 6; k++) begin
      step(I_0);
      chk($sformatf("wd.no_fault_%0d", k), 32'(fault), 32'd0);
    end
    step(I_0);
    chk("wd.fault", 32'(fault), 32'd1);
    chk("wd.fault_stage", 32'(fault_stage), 32'd3);
    chk("wd.running", 32'(running), 32'd0);
    chk("wd.en", 32'(en_now()), 32'd0);
    step(I_S);
    chk("wd.start_ignored_en", 32'(en_now()), 32'd0);
    chk("wd.start_ignored_fault", 32'(fault), 32'd1);
    step(I_ED | I_S);
    chk("wd.late_done_en", 32'(en_now()), 32'd0);
    chk("wd.sticky_stage", 32'(fault_stage), 32'd3);
    chk("wd.retired_held", retired, 32'd5);
    #2 rstn = 1'b0;
    #1 chk_all_zero("wd_reset");
    @(negedge clk);
    rstn = 1'b1;

    // Async reset in the middle of the write stage.
    step(I_S);
    chk("mid.fetch", 32'(en_now()), 32'(E_F));
    step(I_0);
    step(I_FD);
    step(I_0);
    step(I_DD);
    step(I_0);
    step(I_ED);
    step(I_0);
    step(I_WD);
    chk("mid.retired1", retired, 32'd1);
    chk("mid.refetch", 32'(en_now()), 32'(E_F));
    step(I_0);
    step(I_FD);
    step(I_H);
    step(I_DD);
    step(I_0);
    step(I_ED);
    chk("mid.write_en", 32'(en_now()), 32'(E_W));
    chk("mid.running", 32'(running), 32'd1);
    #2 rstn = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge clk);
    rstn = 1'b1;

    // Retired wrap-around; also shows the earlier pending halt was discarded.
    step(I_S);
    step(I_0);
    step(I_FD);
    step(I_0);
    step(I_DD);
    force dut.retired = 32'hFFFF_FFFF;
    step(I_0);
    release dut.retired;
    chk("wrap.preload", retired, 32'hFFFF_FFFF);
    step(I_ED);
    chk("wrap.write_en", 32'(en_now()), 32'(E_W));
    step(I_0);
    step(I_WD);
    chk("wrap.retired", retired, 32'd0);
    chk("wrap.refetch", 32'(en_now()), 32'(E_F));
    chk("wrap.running", 32'(running), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
